// File: rtl/axis_daq_readout_pkg.sv
// Shared types and field positions for the DAQ readout engine.
// No logic here; latency/backpressure are properties of the modules that import it.
package axis_daq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

    localparam int C_RD_FIFO_DEPTH = 4;
    localparam int C_CNT_WIDTH     = 16;

    localparam int C_STAT_DONE_BIT = 0;
    localparam int C_STAT_BUSY_BIT = 1;
    localparam int C_STAT_CNT_LSB  = 16;

    localparam int C_CTL_EN_BIT    = 0;
    localparam int C_CTL_ADDR_LSB  = 16;
    localparam int C_LEN_LSB       = 0;
    localparam int C_LEN_WIDTH     = 16;

endpackage

// File: rtl/axis_daq_readout_fifo.sv
// Small synchronous FIFO with registered storage; a pushed entry is at the head the next cycle.
// No internal flow control: the caller must keep pushes within the free slots reported by count.
module axis_daq_readout_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_dat,
    output logic                       head_vld,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_pop;

    assign do_pop   = pop && (cnt != '0);
    assign head_vld = (cnt != '0);
    assign head_dat = mem[rd_ptr];
    assign count    = cnt;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/axis_daq_readout.sv
// Streams a circular BRAM window as one AXIS packet; first tvalid 3 cycles after enable is sampled.
// Stalls reads while tready is low (max 4 buffered + in flight); AXIS_DAQ_READOUT_BYTESWAP_EN swaps sample bytes.
module axis_daq_readout
    import axis_daq_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int BRAM_DATA_WIDTH  = 16,
    parameter int BRAM_ADDR_WIDTH  = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [31:0]                 rd_control,
    input  logic [31:0]                 rd_length,
    output logic [31:0]                 rd_status,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        bram_portb_clk,
    output logic [BRAM_ADDR_WIDTH-1:0]  bram_portb_addr,
    input  logic [BRAM_DATA_WIDTH-1:0]  bram_portb_rddata,
    output logic                        bram_portb_en
);

    typedef struct packed {
        logic                       last;
        logic [BRAM_DATA_WIDTH-1:0] sample;
    } beat_t;

    localparam int CW = $clog2(C_RD_FIFO_DEPTH) + 1;

    rd_state_e                  state;
    rd_state_e                  state_nxt;
    logic [BRAM_ADDR_WIDTH-1:0] rd_addr;
    logic [C_LEN_WIDTH-1:0]     len;
    logic [C_LEN_WIDTH-1:0]     issued;
    logic [C_CNT_WIDTH-1:0]     beat_cnt;
    logic                       abort_q;
    logic                       rd_vld;
    logic                       rd_last;
    logic [31:0]                status;
    logic [31:0]                status_nxt;

    logic                       rd_enable;
    logic [BRAM_ADDR_WIDTH-1:0] start_addr;
    logic [C_LEN_WIDTH-1:0]     length_in;
    logic                       unused_ctl;

    logic [CW-1:0]              fifo_cnt;
    logic                       fifo_vld;
    beat_t                      push_beat;
    beat_t                      head_beat;
    logic [BRAM_DATA_WIDTH-1:0] sample;

    logic [CW:0]                outstanding;
    logic                       can_issue;
    logic                       issue;
    logic                       pop;
    logic                       drained;
    logic                       aborting;
    logic                       active;

    assign rd_enable  = rd_control[C_CTL_EN_BIT];
    assign start_addr = rd_control[C_CTL_ADDR_LSB +: BRAM_ADDR_WIDTH];
    assign length_in  = rd_length[C_LEN_LSB +: C_LEN_WIDTH];
    assign unused_ctl = ^{rd_control[C_CTL_ADDR_LSB-1:C_CTL_EN_BIT+1], rd_length[31:C_LEN_WIDTH]};

    // Credit counts the in-flight read so the FIFO can never overflow; a pop
    // frees its slot only from the following cycle.
    assign outstanding = {1'b0, fifo_cnt} + {{CW{1'b0}}, rd_vld};
    assign can_issue   = outstanding < (CW+1)'(C_RD_FIFO_DEPTH);
    assign active      = (state == ST_RUN) || (state == ST_DRAIN);
    assign issue       = (state == ST_RUN) && rd_enable && can_issue && (issued != len);
    assign pop         = fifo_vld && m_axis_tready;
    assign drained     = !rd_vld && ((fifo_cnt == '0) || ((fifo_cnt == CW'(1)) && pop));
    assign aborting    = abort_q || !rd_enable;

    always_comb begin
        sample = bram_portb_rddata;
`ifdef AXIS_DAQ_READOUT_BYTESWAP_EN
        for (int i = 0; i < BRAM_DATA_WIDTH/8; i++) begin
            sample[i*8 +: 8] = bram_portb_rddata[BRAM_DATA_WIDTH-8-i*8 +: 8];
        end
`endif
    end

    assign push_beat = {rd_last, sample};

    axis_daq_readout_fifo #(
        .WIDTH (BRAM_DATA_WIDTH + 1),
        .DEPTH (C_RD_FIFO_DEPTH)
    ) u_fifo (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .push     (rd_vld),
        .push_dat (push_beat),
        .pop      (pop),
        .head_dat (head_beat),
        .head_vld (fifo_vld),
        .count    (fifo_cnt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (rd_enable) begin
                    state_nxt = (length_in == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (!rd_enable) begin
                    state_nxt = ST_DRAIN;
                end else if (issue && ((issued + 16'd1) == len)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drained) begin
                    state_nxt = aborting ? ST_IDLE : ST_DONE;
                end
            end
            ST_DONE: begin
                if (!rd_enable) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        status_nxt                                  = '0;
        status_nxt[C_STAT_DONE_BIT]                 = (state == ST_DONE);
        status_nxt[C_STAT_BUSY_BIT]                 = active;
        status_nxt[C_STAT_CNT_LSB +: C_CNT_WIDTH]   = beat_cnt;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= ST_IDLE;
            rd_addr  <= '0;
            len      <= '0;
            issued   <= '0;
            beat_cnt <= '0;
            abort_q  <= 1'b0;
            rd_vld   <= 1'b0;
            rd_last  <= 1'b0;
            status   <= '0;
        end else begin
            state   <= state_nxt;
            rd_vld  <= issue;
            rd_last <= issue && (issued == (len - 16'd1));
            status  <= status_nxt;
            if ((state == ST_IDLE) && rd_enable) begin
                rd_addr  <= start_addr;
                len      <= length_in;
                issued   <= '0;
                beat_cnt <= '0;
                abort_q  <= 1'b0;
            end else begin
                if (issue) begin
                    rd_addr <= rd_addr + 1'b1;
                    issued  <= issued + 16'd1;
                end
                if (pop && (beat_cnt != '1)) begin
                    beat_cnt <= beat_cnt + 16'd1;
                end
                if (active && !rd_enable) begin
                    abort_q <= 1'b1;
                end
            end
        end
    end

    // Beats drained after an abort never close the packet.
    assign m_axis_tvalid   = fifo_vld;
    assign m_axis_tlast    = fifo_vld && head_beat.last && !abort_q;
    assign m_axis_tdata    = {{(AXIS_TDATA_WIDTH-BRAM_DATA_WIDTH){head_beat.sample[BRAM_DATA_WIDTH-1]}},
                              head_beat.sample};
    assign bram_portb_clk  = aclk;
    assign bram_portb_addr = rd_addr;
    assign bram_portb_en   = issue;
    assign rd_status       = status;

endmodule

// File: tb/tb_axis_daq_readout.sv
// Directed bench for axis_daq_readout with a BRAM model and a queue-based beat/address scoreboard.
module tb_axis_daq_readout;

    logic        aclk;
    logic        aresetn;
    logic [31:0] rd_control;
    logic [31:0] rd_length;
    logic [31:0] rd_status;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        bram_portb_clk;
    logic [15:0] bram_portb_addr;
    logic [15:0] bram_portb_rddata;
    logic        bram_portb_en;

    axis_daq_readout #(
        .AXIS_TDATA_WIDTH (32),
        .BRAM_DATA_WIDTH  (16),
        .BRAM_ADDR_WIDTH  (16)
    ) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .rd_control        (rd_control),
        .rd_length         (rd_length),
        .rd_status         (rd_status),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .m_axis_tlast      (m_axis_tlast),
        .bram_portb_clk    (bram_portb_clk),
        .bram_portb_addr   (bram_portb_addr),
        .bram_portb_rddata (bram_portb_rddata),
        .bram_portb_en     (bram_portb_en)
    );

    logic [15:0] mem [65536];
    int          checks;
    int          errors;
    int          cyc;
    int          ready_mode;   // 0 low, 1 high, 2 random

    logic [31:0] exp_dat[$];
    logic        exp_last[$];
    logic [15:0] exp_addr[$];
    int          outst;
    int          acc_cnt;
    int          tlast_cnt;
    int          first_acc_cyc;
    int          last_acc_cyc;
    logic        any_vld;
    logic        first_seen;
    logic [31:0] first_dat;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge aclk);
            cyc++;
        end
    end

    always @(posedge aclk) begin
        if (bram_portb_en) bram_portb_rddata <= mem[bram_portb_addr];
    end

    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            if (ready_mode == 2) m_axis_tready = 1'($urandom_range(0, 1));
            else                 m_axis_tready = (ready_mode == 1);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name, input int n);
        checks++;
        errors++;
        $display("FAIL %s: condition not reached within %0d cycles", name, n);
    endtask

    // Expected stream value straight from the stored sample.
    function automatic logic [31:0] model_dat(input logic [15:0] a);
        logic [15:0] s;
        s = mem[a];
`ifdef AXIS_DAQ_READOUT_BYTESWAP_EN
        s = {s[7:0], s[15:8]};
`endif
        return {{16{s[15]}}, s};
    endfunction

    // Scoreboard: addresses on every read, data/last on every accepted beat, stability on stalls.
    initial begin
        logic        prev_stall;
        logic [31:0] prev_dat;
        logic        prev_last;
        prev_stall = 1'b0;
        prev_dat   = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                prev_stall = 1'b0;
                continue;
            end
            if (bram_portb_en) begin
                if (exp_addr.size() == 0) begin
                    timeout_fail("unexpected_read", 0);
                end else begin
                    check("rd_addr", {16'h0, bram_portb_addr}, {16'h0, exp_addr.pop_front()});
                end
                outst++;
            end
            if (m_axis_tvalid) any_vld = 1'b1;
            if (prev_stall) begin
                check("stall_tvalid", {31'h0, m_axis_tvalid}, 32'd1);
                check("stall_tdata", m_axis_tdata, prev_dat);
                check("stall_tlast", {31'h0, m_axis_tlast}, {31'h0, prev_last});
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_dat.size() == 0) begin
                    timeout_fail("unexpected_beat", 0);
                end else begin
                    check("tdata", m_axis_tdata, exp_dat.pop_front());
                    check("tlast", {31'h0, m_axis_tlast}, {31'h0, exp_last.pop_front()});
                end
                if (!first_seen) begin
                    first_seen    = 1'b1;
                    first_dat     = m_axis_tdata;
                    first_acc_cyc = cyc;
                end
                last_acc_cyc = cyc;
                acc_cnt++;
                outst--;
                if (m_axis_tlast) tlast_cnt++;
            end
            check("outstanding_le_4", {31'h0, outst <= 4}, 32'd1);
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_dat   = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    task automatic start_xfer(input logic [15:0] start, input logic [15:0] len);
        logic [15:0] a;
        exp_dat.delete();
        exp_last.delete();
        exp_addr.delete();
        for (int i = 0; i < int'(len); i++) begin
            a = start + 16'(i);
            exp_addr.push_back(a);
            exp_dat.push_back(model_dat(a));
            exp_last.push_back(i == int'(len) - 1);
        end
        acc_cnt    = 0;
        tlast_cnt  = 0;
        any_vld    = 1'b0;
        first_seen = 1'b0;
        rd_length  = {16'h0, len};
        rd_control = {start, 15'h0, 1'b1};
    endtask

    task automatic finish_xfer(input int len, input bit full_rate);
        int n;
        int done_cyc;
        bit seen;
        n        = 0;
        seen     = 1'b0;
        done_cyc = 0;
        while (!seen && n < 3000) begin
            @(negedge aclk);
            n++;
            if (rd_status[0]) begin
                seen     = 1'b1;
                done_cyc = cyc;
            end
        end
        if (!seen) begin
            timeout_fail("done_timeout", n);
        end else begin
            if (len > 0) check("done_latency", done_cyc - last_acc_cyc, 32'd2);
            check("busy_in_done", {31'h0, rd_status[1]}, 32'd0);
        end
        @(negedge aclk);
        check("beat_count", {16'h0, rd_status[31:16]}, len);
        check("beats_accepted", acc_cnt, len);
        check("tlast_count", tlast_cnt, (len > 0) ? 1 : 0);
        check("outstanding_end", outst, 0);
        check("beats_left", exp_dat.size(), 0);
        if (full_rate && len > 0) check("no_bubbles", last_acc_cyc - first_acc_cyc, len - 1);
        if (len == 0) check("no_tvalid", {31'h0, any_vld}, 32'd0);
        @(posedge aclk);
        #1;
        rd_control[0] = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("done_cleared", {31'h0, rd_status[0]}, 32'd0);
    endtask

    initial begin
        int n;
        int en_cyc;
        int vld_cyc;
        logic [15:0] a;
        checks     = 0;
        errors     = 0;
        ready_mode = 0;
        outst      = 0;
        acc_cnt    = 0;
        tlast_cnt  = 0;
        any_vld    = 1'b0;
        first_seen = 1'b0;
        first_dat  = '0;
        first_acc_cyc = 0;
        last_acc_cyc  = 0;
        aresetn    = 1'b0;
        rd_control = '0;
        rd_length  = '0;
        for (int i = 0; i < 65536; i++) begin
            a      = 16'(i);
            mem[i] = {a[7:0], a[15:8]} ^ 16'h8000;
        end

        repeat (3) @(posedge aclk);
        #1;
        check("rst_tvalid", {31'h0, m_axis_tvalid}, 32'd0);
        check("rst_tlast", {31'h0, m_axis_tlast}, 32'd0);
        check("rst_tdata", m_axis_tdata, 32'd0);
        check("rst_addr", {16'h0, bram_portb_addr}, 32'd0);
        check("rst_en", {31'h0, bram_portb_en}, 32'd0);
        check("rst_status", rd_status, 32'd0);
        aresetn = 1'b1;
        ready_mode = 1;
        repeat (2) @(posedge aclk);
        #1;

        // Basic transfer with pipeline latency checks
        start_xfer(16'h0010, 16'd8);
        n = 0;
        en_cyc  = -1;
        vld_cyc = -1;
        while (n < 20 && vld_cyc < 0) begin
            @(posedge aclk);
            n++;
            #1;
            if (bram_portb_en && en_cyc < 0) en_cyc = n;
            if (m_axis_tvalid) vld_cyc = n;
        end
        check("first_en_cycle", en_cyc, 32'd1);
        check("first_tvalid_cycle", vld_cyc, 32'd3);
        finish_xfer(8, 1'b1);
`ifdef AXIS_DAQ_READOUT_BYTESWAP_EN
        check("basic_first_dat", first_dat, 32'h0000_0090);
`else
        check("basic_first_dat", first_dat, 32'hFFFF_9000);
`endif

        // Wrap-around FFFE..0001
        @(posedge aclk);
        #1;
        start_xfer(16'hFFFE, 16'd4);
        finish_xfer(4, 1'b1);
`ifdef AXIS_DAQ_READOUT_BYTESWAP_EN
        check("wrap_first_dat", first_dat, 32'hFFFF_FF7E);
`else
        check("wrap_first_dat", first_dat, 32'h0000_7EFF);
`endif

        // Random backpressure
        ready_mode = 2;
        @(posedge aclk);
        #1;
        start_xfer(16'h1234, 16'd16);
        finish_xfer(16, 1'b0);
        ready_mode = 1;

        // Empty transfer
        @(posedge aclk);
        #1;
        start_xfer(16'h0040, 16'd0);
        finish_xfer(0, 1'b0);

        // Single beat at the top address
        @(posedge aclk);
        #1;
        start_xfer(16'hFFFF, 16'd1);
        finish_xfer(1, 1'b1);
`ifdef AXIS_DAQ_READOUT_BYTESWAP_EN
        check("single_dat", first_dat, 32'hFFFF_FF7F);
`else
        check("single_dat", first_dat, 32'h0000_7FFF);
`endif

        // Abort after 5 accepted beats of 32
        @(posedge aclk);
        #1;
        start_xfer(16'h0200, 16'd32);
        n = 0;
        while (acc_cnt < 5 && n < 100) begin
            @(posedge aclk);
            n++;
            #1;
        end
        if (acc_cnt < 5) timeout_fail("abort_wait_beats", n);
        rd_control[0] = 1'b0;
        n = 0;
        while (rd_status[1] && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (rd_status[1]) timeout_fail("abort_busy_clear", n);
        repeat (3) @(negedge aclk);
        check("abort_done", {31'h0, rd_status[0]}, 32'd0);
        check("abort_busy", {31'h0, rd_status[1]}, 32'd0);
        check("abort_count", {16'h0, rd_status[31:16]}, acc_cnt);
        check("abort_tlast", tlast_cnt, 32'd0);
        check("abort_outstanding", outst, 32'd0);
        check("abort_reads_eq_beats", exp_addr.size(), 32 - acc_cnt);
        check("abort_bounded", {31'h0, (acc_cnt >= 5) && (acc_cnt <= 9)}, 32'd1);
        exp_dat.delete();
        exp_last.delete();
        exp_addr.delete();

        // Async reset in RUN while a beat is stalled
        ready_mode = 0;
        @(posedge aclk);
        #1;
        start_xfer(16'h0300, 16'd16);
        n = 0;
        while (!m_axis_tvalid && n < 20) begin
            @(posedge aclk);
            n++;
            #1;
        end
        if (!m_axis_tvalid) timeout_fail("reset_wait_tvalid", n);
        @(posedge aclk);
        #3;
        aresetn    = 1'b0;
        rd_control = '0;
        #1;
        check("mid_rst_tvalid", {31'h0, m_axis_tvalid}, 32'd0);
        check("mid_rst_tlast", {31'h0, m_axis_tlast}, 32'd0);
        check("mid_rst_tdata", m_axis_tdata, 32'd0);
        check("mid_rst_addr", {16'h0, bram_portb_addr}, 32'd0);
        check("mid_rst_en", {31'h0, bram_portb_en}, 32'd0);
        check("mid_rst_status", rd_status, 32'd0);
        exp_dat.delete();
        exp_last.delete();
        exp_addr.delete();
        outst = 0;
        repeat (2) @(posedge aclk);
        #3;
        aresetn = 1'b1;
        ready_mode = 1;
        repeat (2) @(posedge aclk);
        #1;
        check("post_rst_idle", rd_status, 32'd0);
        start_xfer(16'h0010, 16'd3);
        finish_xfer(3, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
